// File: rtl/foc_cmd_arb.sv
// foc_cmd_arb: arbitrates N_SRC command sources into one target/damping pair for the FOC loop,
//   with a command watchdog, a zero-drive period, an overtemp integrator and an overtemp lockout.
// Latency: an accepted strobe at edge N moves the FSM and loads the held regs at N; foc_target is valid after N+1.
// Backpressure: none; strobes from disabled sources are dropped, and accepts in OVERTEMP update only the held regs.
// Ports: c/rst clock and sync reset; cmd_dv/cmd_target/cmd_damping/src_enable per-source command inputs;
//   foc_active_req/overtemp/ignore_temperature/overtemp_rst control inputs; foc_target/foc_damping/foc_active/
//   float/cmd_src/state/overtemp_latch/timeout_evt outputs.
module foc_cmd_arb #(
    parameter int N_SRC            = 2,
    parameter int SRC_W            = 1,
    parameter int W                = 32,
    parameter int CNT_W            = 24,
    parameter int TARGET_TIMEOUT   = 10_000_000,
    parameter int ZERO_TIMEOUT     = 10_000_000,
    parameter int OVERTEMP_TIMEOUT = 1_000_000
) (
    input  logic               c,
    input  logic               rst,
    input  logic [N_SRC-1:0]   cmd_dv,
    input  logic [N_SRC*W-1:0] cmd_target,
    input  logic [N_SRC*W-1:0] cmd_damping,
    input  logic [N_SRC-1:0]   src_enable,
    input  logic               foc_active_req,
    input  logic               overtemp,
    input  logic               ignore_temperature,
    input  logic               overtemp_rst,
    output logic [W-1:0]       foc_target,
    output logic [W-1:0]       foc_damping,
    output logic               foc_active,
    output logic               float,
    output logic [SRC_W-1:0]   cmd_src,
    output logic [1:0]         state,
    output logic               overtemp_latch,
    output logic               timeout_evt
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RUNNING    = 2'd1,
        DRIVE_ZERO = 2'd2,
        OVERTEMP   = 2'd3
    } st_t;

    localparam logic [CNT_W-1:0] TT_C  = CNT_W'(TARGET_TIMEOUT);
    localparam logic [CNT_W-1:0] ZT_C  = CNT_W'(ZERO_TIMEOUT);
    localparam logic [CNT_W-1:0] OTT_C = CNT_W'(OVERTEMP_TIMEOUT);
    localparam logic [CNT_W-1:0] MAX_C = {CNT_W{1'b1}};

    st_t              st_q, st_nx;
    logic             accept;
    logic [SRC_W-1:0] win_idx;
    logic [W-1:0]     win_target, win_damping;
    logic [W-1:0]     held_target, held_damping;
    logic [CNT_W-1:0] wd_cnt, zero_cnt, ot_cnt;
    logic             timeout, trip, revoke;
    logic             set_latch, tevt_nx;

    assign state = st_q;

    // Walk from the highest index down so the lowest enabled strobe ends up as the winner.
    always_comb begin
        accept      = 1'b0;
        win_idx     = '0;
        win_target  = '0;
        win_damping = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (cmd_dv[i] && src_enable[i]) begin
                accept      = 1'b1;
                win_idx     = SRC_W'(i);
                win_target  = cmd_target[i*W +: W];
                win_damping = cmd_damping[i*W +: W];
            end
        end
    end

    assign timeout = (wd_cnt == TT_C) && !accept;
    assign trip    = ot_cnt > OTT_C;
    assign revoke  = (st_q == RUNNING) && !src_enable[cmd_src];

    // State register
    always_ff @(posedge c) begin
        if (rst) st_q <= IDLE;
        else     st_q <= st_nx;
    end

    // Next-state logic
    always_comb begin
        st_nx = st_q;
        case (st_q)
            IDLE:       if (accept) st_nx = RUNNING;
            RUNNING: begin
                if (trip || timeout || (revoke && !accept)) st_nx = DRIVE_ZERO;
            end
            DRIVE_ZERO: begin
                if (accept && !overtemp_latch) st_nx = RUNNING;
                else if (zero_cnt == ZT_C)     st_nx = overtemp_latch ? OVERTEMP : IDLE;
            end
            OVERTEMP:   if (!overtemp_latch) st_nx = IDLE;
            default:    st_nx = IDLE;
        endcase
    end

    // Output logic; an overtemp trip outranks a watchdog timeout, so the pulse only fires without a trip.
    always_comb begin
        foc_active = foc_active_req && ((st_q == RUNNING) || (st_q == DRIVE_ZERO));
        float      = (st_q == IDLE) || (st_q == OVERTEMP);
        set_latch  = (st_q == RUNNING) && trip;
        tevt_nx    = (st_q == RUNNING) && !trip && timeout;
    end

    always_ff @(posedge c) begin
        if (rst) begin
            held_target    <= '0;
            held_damping   <= '0;
            cmd_src        <= '0;
            wd_cnt         <= '0;
            zero_cnt       <= '0;
            ot_cnt         <= '0;
            overtemp_latch <= 1'b0;
            timeout_evt    <= 1'b0;
            foc_target     <= '0;
            foc_damping    <= '0;
        end else begin
            if (accept) begin
                held_target  <= win_target;
                held_damping <= win_damping;
                cmd_src      <= win_idx;
            end

            if (accept)              wd_cnt <= '0;
            else if (wd_cnt != TT_C) wd_cnt <= wd_cnt + 1'b1;

            // Zero-drive counter only runs while parked in DRIVE_ZERO.
            if ((st_nx != st_q) || (st_q != DRIVE_ZERO)) zero_cnt <= '0;
            else if (zero_cnt != MAX_C)                  zero_cnt <= zero_cnt + 1'b1;

            if (ignore_temperature)  ot_cnt <= '0;
            else if (overtemp) begin
                if (ot_cnt != MAX_C) ot_cnt <= ot_cnt + 1'b1;
            end
            else if (ot_cnt != '0)   ot_cnt <= ot_cnt - 1'b1;

            // Clearing wins over a same-cycle trip.
            if (overtemp_rst)   overtemp_latch <= 1'b0;
            else if (set_latch) overtemp_latch <= 1'b1;

            timeout_evt <= tevt_nx;
            foc_target  <= (st_q == RUNNING) ? held_target  : '0;
            foc_damping <= (st_q == RUNNING) ? held_damping : '0;
        end
    end

endmodule

// File: tb/tb_foc_cmd_arb.sv
// tb_foc_cmd_arb: directed scenarios for foc_cmd_arb with small timeouts (100/20/10) and three sources.
// Latency: outputs checked 1ns after the rising edge that produced them.
// Backpressure: not applicable; every strobe is a single cycle.
module tb_foc_cmd_arb;

    localparam int N_SRC = 3;
    localparam int SRC_W = 2;
    localparam int W     = 32;

    logic               c = 1'b0;
    logic               rst;
    logic [N_SRC-1:0]   cmd_dv;
    logic [N_SRC*W-1:0] cmd_target;
    logic [N_SRC*W-1:0] cmd_damping;
    logic [N_SRC-1:0]   src_enable;
    logic               foc_active_req, overtemp, ignore_temperature, overtemp_rst;
    logic [W-1:0]       foc_target, foc_damping;
    logic               foc_active, float, overtemp_latch, timeout_evt;
    logic [SRC_W-1:0]   cmd_src;
    logic [1:0]         state;

    int checks   = 0;
    int failures = 0;

    localparam logic [W-1:0] T0 = 32'h4000_0000, D0 = 32'h3f00_0000;
    localparam logic [W-1:0] T1 = 32'h3f80_0000, D1 = 32'h3dcc_cccd;
    localparam logic [W-1:0] T2 = 32'h4040_0000, D2 = 32'h3e80_0000;

    foc_cmd_arb #(
        .N_SRC(N_SRC), .SRC_W(SRC_W), .W(W), .CNT_W(24),
        .TARGET_TIMEOUT(100), .ZERO_TIMEOUT(20), .OVERTEMP_TIMEOUT(10)
    ) dut (
        .c(c), .rst(rst), .cmd_dv(cmd_dv), .cmd_target(cmd_target), .cmd_damping(cmd_damping),
        .src_enable(src_enable), .foc_active_req(foc_active_req), .overtemp(overtemp),
        .ignore_temperature(ignore_temperature), .overtemp_rst(overtemp_rst),
        .foc_target(foc_target), .foc_damping(foc_damping), .foc_active(foc_active),
        .float(float), .cmd_src(cmd_src), .state(state), .overtemp_latch(overtemp_latch),
        .timeout_evt(timeout_evt)
    );

    always #5 c = ~c;

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic strobe(input logic [N_SRC-1:0] mask);
        cmd_dv = mask;
        tick();
        cmd_dv = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (float !== 1'b1) begin failures++; $display("FAIL reset_float got=%0b exp=1", float); end
        checks++; if (foc_active !== 1'b0) begin failures++; $display("FAIL reset_active got=%0b exp=0", foc_active); end
        checks++; if (foc_target !== 32'h0 || foc_damping !== 32'h0) begin failures++;
            $display("FAIL reset_words got=%h/%h exp=0/0", foc_target, foc_damping); end
        checks++; if (cmd_src !== 2'd0 || overtemp_latch !== 1'b0 || timeout_evt !== 1'b0) begin failures++;
            $display("FAIL reset_misc got src=%0d latch=%0b tevt=%0b exp=0/0/0", cmd_src, overtemp_latch, timeout_evt); end
        rst = 1'b0;
    endtask

    task automatic test_accept();
        do_reset();
        strobe(3'b010);
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL acc_state got=%0d exp=1", state); end
        checks++; if (cmd_src !== 2'd1) begin failures++; $display("FAIL acc_src got=%0d exp=1", cmd_src); end
        checks++; if (float !== 1'b0 || foc_active !== 1'b1) begin failures++;
            $display("FAIL acc_flags got float=%0b active=%0b exp=0/1", float, foc_active); end
        checks++; if (foc_target !== 32'h0) begin failures++; $display("FAIL acc_early got=%h exp=0", foc_target); end
        tick();
        checks++; if (foc_target !== T1 || foc_damping !== D1) begin failures++;
            $display("FAIL acc_words got=%h/%h exp=%h/%h", foc_target, foc_damping, T1, D1); end
        foc_active_req = 1'b0;
        #1;
        checks++; if (foc_active !== 1'b0) begin failures++; $display("FAIL acc_req_off got=%0b exp=0", foc_active); end
        foc_active_req = 1'b1;
    endtask

    task automatic test_priority();
        do_reset();
        strobe(3'b101);
        checks++; if (cmd_src !== 2'd0) begin failures++; $display("FAIL prio_low got=%0d exp=0", cmd_src); end
        do_reset();
        src_enable = 3'b110;
        strobe(3'b101);
        tick();
        checks++; if (cmd_src !== 2'd2 || foc_target !== T2) begin failures++;
            $display("FAIL prio_masked got src=%0d tgt=%h exp=2/%h", cmd_src, foc_target, T2); end
        do_reset();
        strobe(3'b001);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL prio_disabled got=%0d exp=0", state); end
        src_enable = 3'b111;
    endtask

    task automatic test_watchdog();
        do_reset();
        src_enable = 3'b110;
        strobe(3'b010);
        // A disabled strobe half way through must not restart the watchdog.
        for (int k = 1; k <= 100; k++) begin
            if (k == 50) cmd_dv = 3'b001;
            tick();
            cmd_dv = '0;
        end
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL wd_hold got=%0d exp=1", state); end
        tick();
        checks++; if (state !== 2'd2 || timeout_evt !== 1'b1) begin failures++;
            $display("FAIL wd_trip got state=%0d tevt=%0b exp=2/1", state, timeout_evt); end
        tick();
        checks++; if (foc_target !== 32'h0 || timeout_evt !== 1'b0) begin failures++;
            $display("FAIL wd_zero got tgt=%h tevt=%0b exp=0/0", foc_target, timeout_evt); end
        for (int k = 0; k < 19; k++) tick();
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL wd_dz_hold got=%0d exp=2", state); end
        tick();
        checks++; if (state !== 2'd0 || float !== 1'b1) begin failures++;
            $display("FAIL wd_idle got state=%0d float=%0b exp=0/1", state, float); end
        src_enable = 3'b111;

        do_reset();
        strobe(3'b010);
        for (int k = 0; k < 100; k++) tick();
        strobe(3'b100);
        checks++; if (state !== 2'd1 || timeout_evt !== 1'b0) begin failures++;
            $display("FAIL wd_edge_acc got state=%0d tevt=%0b exp=1/0", state, timeout_evt); end
        tick(); tick();
        checks++; if (state !== 2'd1 || foc_target !== T2) begin failures++;
            $display("FAIL wd_edge_hold got state=%0d tgt=%h exp=1/%h", state, foc_target, T2); end
    endtask

    task automatic test_overtemp();
        do_reset();
        strobe(3'b001);
        overtemp = 1'b1;
        for (int k = 0; k < 11; k++) tick();
        overtemp = 1'b0;
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL ot_no_trip_at_10 got=%0d exp=1", state); end
        tick();
        checks++; if (state !== 2'd2 || overtemp_latch !== 1'b1) begin failures++;
            $display("FAIL ot_trip got state=%0d latch=%0b exp=2/1", state, overtemp_latch); end
        strobe(3'b010);
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL ot_dz_ignore got=%0d exp=2", state); end
        for (int k = 0; k < 19; k++) tick();
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL ot_dz_hold got=%0d exp=2", state); end
        tick();
        checks++; if (state !== 2'd3 || float !== 1'b1 || foc_active !== 1'b0) begin failures++;
            $display("FAIL ot_lock got state=%0d float=%0b active=%0b exp=3/1/0", state, float, foc_active); end
        strobe(3'b001);
        checks++; if (state !== 2'd3) begin failures++; $display("FAIL ot_lock_ignore got=%0d exp=3", state); end
        overtemp_rst = 1'b1;
        tick();
        overtemp_rst = 1'b0;
        checks++; if (overtemp_latch !== 1'b0) begin failures++; $display("FAIL ot_clear got=%0b exp=0", overtemp_latch); end
        tick();
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL ot_idle got=%0d exp=0", state); end
        strobe(3'b100);
        checks++; if (state !== 2'd1 || cmd_src !== 2'd2) begin failures++;
            $display("FAIL ot_resume got state=%0d src=%0d exp=1/2", state, cmd_src); end

        do_reset();
        strobe(3'b001);
        for (int k = 0; k < 40; k++) begin
            overtemp = (k % 2 == 0);
            tick();
        end
        overtemp = 1'b0;
        checks++; if (state !== 2'd1 || overtemp_latch !== 1'b0) begin failures++;
            $display("FAIL ot_toggle got state=%0d latch=%0b exp=1/0", state, overtemp_latch); end
    endtask

    task automatic test_revoke();
        do_reset();
        strobe(3'b100);
        checks++; if (state !== 2'd1 || cmd_src !== 2'd2) begin failures++;
            $display("FAIL rv_run got state=%0d src=%0d exp=1/2", state, cmd_src); end
        src_enable = 3'b011;
        tick();
        checks++; if (state !== 2'd2 || timeout_evt !== 1'b0) begin failures++;
            $display("FAIL rv_drop got state=%0d tevt=%0b exp=2/0", state, timeout_evt); end
        strobe(3'b001);
        checks++; if (state !== 2'd1 || cmd_src !== 2'd0) begin failures++;
            $display("FAIL rv_resume got state=%0d src=%0d exp=1/0", state, cmd_src); end
        tick();
        checks++; if (foc_target !== T0 || foc_damping !== D0) begin failures++;
            $display("FAIL rv_words got=%h/%h exp=%h/%h", foc_target, foc_damping, T0, D0); end
        src_enable = 3'b111;
    endtask

    task automatic test_mid_reset();
        do_reset();
        strobe(3'b010);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (state !== 2'd0 || float !== 1'b1 || foc_target !== 32'h0 || cmd_src !== 2'd0) begin failures++;
            $display("FAIL mr_run got state=%0d float=%0b tgt=%h src=%0d exp=0/1/0/0", state, float, foc_target, cmd_src); end

        strobe(3'b100);
        overtemp = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        overtemp = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (state !== 2'd0 || overtemp_latch !== 1'b0 || foc_damping !== 32'h0) begin failures++;
            $display("FAIL mr_latch got state=%0d latch=%0b dmp=%h exp=0/0/0", state, overtemp_latch, foc_damping); end
        // The integrator must have been cleared too: a fresh run stays up with no overtemp.
        strobe(3'b001);
        tick();
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL mr_integrator got=%0d exp=1", state); end
    endtask

    initial begin
        rst                = 1'b1;
        cmd_dv             = '0;
        cmd_target         = {T2, T1, T0};
        cmd_damping        = {D2, D1, D0};
        src_enable         = 3'b111;
        foc_active_req     = 1'b1;
        overtemp           = 1'b0;
        ignore_temperature = 1'b0;
        overtemp_rst       = 1'b0;

        test_reset();
        test_accept();
        test_priority();
        test_watchdog();
        test_overtemp();
        test_revoke();
        test_mid_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/foc_cmd_arb.md
Name: foc_cmd_arb

Overview:
Parametrised successor to the single-pair FOC command selector. Arbitrates N_SRC command sources (UDP register path, submessage decoder, future CAN/debug paths) into one target/damping pair for the FOC loop. Also provides:
- command watchdog with zero-drive period,
- saturating overtemp integrator with latched overtemp lockout,
- per-source enables and revocation of the active source.

Sits between command decoders and the FOC current loop; temperature comparison is done upstream (single-bit overtemp input).

Parameters:
N_SRC, 2, number of command sources (1..8)
SRC_W, 1, width of source index; must be >= clog2(N_SRC), minimum 1
W, 32, width of target and damping words (opaque, e.g. IEEE754 single)
CNT_W, 24, width of watchdog, zero-drive and overtemp counters
TARGET_TIMEOUT, 10_000_000, cycles without accepted command before zero-drive
ZERO_TIMEOUT, 10_000_000, cycles spent driving zero before idle/overtemp
OVERTEMP_TIMEOUT, 1_000_000, integrator threshold; trip when count > this

Ports:
c  in  1  clock
rst  in  1  synchronous active-high reset
cmd_dv  in  N_SRC  per-source one-cycle command strobe
cmd_target  in  N_SRC*W  per-source target; source i at bits [i*W +: W]
cmd_damping  in  N_SRC*W  per-source damping; same packing
src_enable  in  N_SRC  per-source enable; disabled strobes are ignored
foc_active_req  in  1  host request to enable the FOC bridge
overtemp  in  1  qualified overtemperature flag (hard or soft limit)
ignore_temperature  in  1  holds integrator at zero while high
overtemp_rst  in  1  clears overtemp latch
foc_target  out  W  registered target to FOC loop
foc_damping  out  W  registered damping to FOC loop
foc_active  out  1  bridge enable
float  out  1  bridge floating (IDLE or OVERTEMP)
cmd_src  out  SRC_W  index of last accepted source
state  out  2  FSM state: 0 IDLE, 1 RUNNING, 2 DRIVE_ZERO, 3 OVERTEMP
overtemp_latch  out  1  overtemp lockout flag
timeout_evt  out  1  one-cycle pulse on watchdog-caused RUNNING->DRIVE_ZERO

Behaviour:
- Reset values:
  - state IDLE, so float=1 and foc_active=0.
  - foc_target, foc_damping, cmd_src, held regs and all counters 0.
  - overtemp_latch 0, timeout_evt 0.
- Accept: acc_i = cmd_dv[i] & src_enable[i]; accept = OR of acc_i.
  - Lowest index wins among simultaneous strobes.
  - On accept, held_target/held_damping/cmd_src load the winner's words at the clock edge.
- Watchdog counter:
  - Cleared on accept; otherwise increments, saturating at TARGET_TIMEOUT.
  - timeout = (count == TARGET_TIMEOUT) & ~accept.
- Overtemp integrator:
  - rst or ignore_temperature: 0.
  - Else overtemp high: +1, saturating at 2^CNT_W-1.
  - Else nonzero: -1.
  - Else hold.
  - trip = count > OVERTEMP_TIMEOUT.
- Revoke: src_enable[cmd_src] low while RUNNING.
- FSM (registered state); zero-drive counter cleared on every state change:
  - IDLE: accept -> RUNNING.
  - RUNNING, in priority order:
    - trip -> DRIVE_ZERO, set overtemp_latch;
    - timeout -> DRIVE_ZERO, pulse timeout_evt;
    - revoke and no accept -> DRIVE_ZERO;
    - else stay.
  - DRIVE_ZERO:
    - accept & ~overtemp_latch -> RUNNING;
    - else when zero count reaches ZERO_TIMEOUT: overtemp_latch -> OVERTEMP, else -> IDLE.
  - OVERTEMP: ~overtemp_latch -> IDLE; accepts are ignored.
- overtemp_latch: overtemp_rst has priority over set in the same cycle. Clearing the latch in DRIVE_ZERO allows a later accept to resume RUNNING.
- Outputs:
  - foc_target/foc_damping are registered: held value when state==RUNNING, else 0.
  - Latency: strobe at edge N loads held regs and moves IDLE->RUNNING at N; foc_target is valid after edge N+1.
  - A new command while RUNNING appears one cycle after the held update.
- foc_active = foc_active_req & (state RUNNING or DRIVE_ZERO); combinational from state.
- float = state IDLE or OVERTEMP.
- rst mid-operation returns to reset values on the next edge, regardless of state; the latch is cleared.

Test Plan:
Bench parameters: N_SRC=3, TARGET_TIMEOUT=100, ZERO_TIMEOUT=20, OVERTEMP_TIMEOUT=10.
1. Accept/latency: strobe src1 with target 0x3f800000 -> state=1 next cycle, foc_target=0x3f800000 one cycle later, cmd_src=1, float=0.
2. Priority/enable:
   - Strobe src0 and src2 together -> cmd_src=0.
   - With src_enable[0]=0, the same pair -> cmd_src=2.
   - Strobe on a disabled source alone -> state stays IDLE and the watchdog is not cleared.
3. Watchdog:
   - No commands after one accept -> RUNNING for 100 cycles, timeout_evt pulse, foc_target=0, after 20 more cycles IDLE, float=1.
   - Accept on the cycle count hits 100 -> stays RUNNING, no pulse.
4. Overtemp:
   - Hold overtemp 11 cycles -> DRIVE_ZERO, latch=1, accepts ignored, after 20 cycles OVERTEMP.
   - overtemp_rst -> IDLE, after which an accept -> RUNNING.
   - overtemp toggling 1/0 never trips.
5. Revoke: RUNNING on src2, drop src_enable[2] -> DRIVE_ZERO next cycle; an accept from src0 during zero-drive -> RUNNING with cmd_src=0.
6. Reset mid-RUNNING with latch set -> next cycle all outputs at reset values, state=0, float=1, overtemp_latch=0.
